data_sequencer: RTL

//   Drives the data medium's sample address to stream (x, y) training pairs to the trainer. Runs
//   num_samples samples per epoch for num_epochs epochs, then stops. Waits for the medium's

---
 rtl/bitnet_data_pkg.sv | 34 +++
 rtl/data_perm_lfsr.sv | 57 +++++
 rtl/data_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/bitnet_data_pkg.sv
// rtl/bitnet_data_pkg.sv - shared types, constants and helpers for the data sequencer
//
// Purpose: sequencer FSM state encoding, width helper functions and the
//          shuffle LFSR seed/taps with its single-step function.
// Ports:   none (package).
// Config:  the LFSR items are only used when DATA_SEQ_SHUFFLE_EN is defined.

package bitnet_data_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_SETTLE,
      S_WAIT,
      S_PRESENT
   } seq_state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic int addr_size(input int addrs);
      return $clog2(addrs);
   endfunction

   function automatic int x_width(input int pieces, input int bram_width);
      return pieces * bram_width;
   endfunction

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/data_perm_lfsr.sv
// rtl/data_perm_lfsr.sv - per-epoch affine address permutation driven by a 16-bit LFSR
//
// Purpose: holds the LFSR and the current epoch's stride/offset, and maps a
//          sample index to perm = (idx*stride + offset) mod 2**ADDR_SIZE.
//          Used by data_sequencer only when DATA_SEQ_SHUFFLE_EN is defined.
// Ports:
//   clk_i     in   1          clock
//   rst_i     in   1          asynchronous active-high reset
//   reload_i  in   1          pick a new stride/offset (advances the LFSR twice)
//   idx_i     in   ADDR_SIZE  sample index within the epoch
//   perm_o    out  ADDR_SIZE  permuted medium address

module data_perm_lfsr
   import bitnet_data_pkg::*;
#(
   parameter int ADDR_SIZE = 10
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 reload_i,
   input  logic [ADDR_SIZE-1:0] idx_i,
   output logic [ADDR_SIZE-1:0] perm_o
);

   logic [15:0]          lfsr_q, lfsr_d, step1;
   logic [ADDR_SIZE-1:0] stride_q, stride_d;
   logic [ADDR_SIZE-1:0] offset_q, offset_d;

   // Both LFSR steps happen in one cycle: the first supplies the stride, the second the offset.
   always_comb begin
      step1    = lfsr_step(lfsr_q);
      lfsr_d   = lfsr_q;
      stride_d = stride_q;
      offset_d = offset_q;
      if (reload_i) begin
         lfsr_d   = lfsr_step(step1);
         // An odd stride is a unit mod 2**ADDR_SIZE, so the map is a bijection.
         stride_d = step1[ADDR_SIZE-1:0] | ADDR_SIZE'(1);
         offset_d = lfsr_d[ADDR_SIZE-1:0];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lfsr_q   <= LFSR_SEED;
         stride_q <= ADDR_SIZE'(1);
         offset_q <= '0;
      end else begin
         lfsr_q   <= lfsr_d;
         stride_q <= stride_d;
         offset_q <= offset_d;
      end
   end

   assign perm_o = idx_i * stride_q + offset_q;

endmodule

// File: rtl/data_sequencer.sv
// rtl/data_sequencer.sv - streams (x, y) training pairs from the data medium to the trainer
//
// Purpose: for each of num_epochs epochs, addresses num_samples samples of the
//          medium, waits for its finished flag, registers the pair and offers it
//          over valid/ready. Define DATA_SEQ_SHUFFLE_EN for a per-epoch shuffled
//          order (data_perm_lfsr); otherwise samples go out in address order.
// Ports:
//   clk_in, rst_in            clock, asynchronous active-high reset
//   start_in, abort_in        run control pulses (abort wins over start)
//   num_samples_in            samples per epoch (ADDR_SIZE+1 bits)
//   num_epochs_in             epochs per run
//   med_addr_out              address to the medium
//   med_x_in, med_y_in        medium sample data
//   med_finished_in           medium read complete
//   x_out, y_out              registered pair
//   sample_addr_out           medium address of the presented pair
//   valid_out, ready_in       pair handshake
//   last_out                  presented pair is last of its epoch
//   epoch_out                 current epoch index
//   epoch_done_out, done_out  one-cycle completion pulses
//   busy_out                  run in progress

module data_sequencer
   import bitnet_data_pkg::*;
#(
   parameter int ADDRS      = 1024,
   parameter int BRAM_WIDTH = 64,
   parameter int PIECES     = 16,
   parameter int EPOCH_W    = 16
) (
   input  logic                                   clk_in,
   input  logic                                   rst_in,
   input  logic                                   start_in,
   input  logic                                   abort_in,
   input  logic [addr_size(ADDRS):0]              num_samples_in,
   input  logic [EPOCH_W-1:0]                     num_epochs_in,
   output logic [addr_size(ADDRS)-1:0]            med_addr_out,
   input  logic [x_width(PIECES, BRAM_WIDTH)-1:0] med_x_in,
   input  logic [x_width(PIECES, BRAM_WIDTH)-1:0] med_y_in,
   input  logic                                   med_finished_in,
   output logic [x_width(PIECES, BRAM_WIDTH)-1:0] x_out,
   output logic [x_width(PIECES, BRAM_WIDTH)-1:0] y_out,
   output logic [addr_size(ADDRS)-1:0]            sample_addr_out,
   output logic                                   valid_out,
   input  logic                                   ready_in,
   output logic                                   last_out,
   output logic [EPOCH_W-1:0]                     epoch_out,
   output logic                                   epoch_done_out,
   output logic                                   done_out,
   output logic                                   busy_out
);

   localparam int ADDR_SIZE = addr_size(ADDRS);
   localparam int X_WIDTH   = x_width(PIECES, BRAM_WIDTH);

   seq_state_t           state_q, state_d;
   logic [ADDR_SIZE:0]   num_samples_q, num_samples_d, presented_q, presented_d;
   logic [EPOCH_W-1:0]   num_epochs_q, num_epochs_d, epoch_q, epoch_d;
   logic [ADDR_SIZE-1:0] idx_q, idx_d, med_addr_q, med_addr_d, sample_addr_q, sample_addr_d;
   logic [X_WIDTH-1:0]   x_q, x_d, y_q, y_d;
   logic                 valid_q, valid_d, busy_q, busy_d;
   logic                 done_q, done_d, epoch_done_q, epoch_done_d;
   logic                 perm_reload;
   logic [ADDR_SIZE-1:0] perm;
   logic                 last_pair, final_epoch;

`ifdef DATA_SEQ_SHUFFLE_EN
   data_perm_lfsr #(.ADDR_SIZE(ADDR_SIZE)) u_perm (
      .clk_i    (clk_in),
      .rst_i    (rst_in),
      .reload_i (perm_reload),
      .idx_i    (idx_q),
      .perm_o   (perm)
   );
`else
   logic unused_reload;
   assign unused_reload = perm_reload;
   assign perm          = idx_q;
`endif

   assign last_pair   = (presented_q == num_samples_q - 1'b1);
   assign final_epoch = (epoch_q == num_epochs_q - 1'b1);

   always_comb begin
      state_d       = state_q;
      num_samples_d = num_samples_q;
      num_epochs_d  = num_epochs_q;
      presented_d   = presented_q;
      epoch_d       = epoch_q;
      idx_d         = idx_q;
      med_addr_d    = med_addr_q;
      sample_addr_d = sample_addr_q;
      x_d           = x_q;
      y_d           = y_q;
      valid_d       = valid_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      epoch_done_d  = 1'b0;
      perm_reload   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_in) begin
               num_samples_d = num_samples_in;
               num_epochs_d  = num_epochs_in;
               epoch_d       = '0;
               idx_d         = '0;
               presented_d   = '0;
               if (num_samples_in == '0 || num_epochs_in == '0) begin
                  done_d = 1'b1;
               end else begin
                  busy_d      = 1'b1;
                  perm_reload = 1'b1;
                  state_d     = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            // Shuffled addresses beyond the sample count are skipped one per cycle.
            if ({1'b0, perm} >= num_samples_q) begin
               idx_d = idx_q + 1'b1;
            end else begin
               med_addr_d = perm;
               state_d    = S_SETTLE;
            end
         end
         S_SETTLE: begin
            // The medium's finished flag may still reflect the previous address here.
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (med_finished_in) begin
               x_d           = med_x_in;
               y_d           = med_y_in;
               sample_addr_d = med_addr_q;
               valid_d       = 1'b1;
               state_d       = S_PRESENT;
            end
         end
         S_PRESENT: begin
            if (ready_in) begin
               valid_d     = 1'b0;
               idx_d       = idx_q + 1'b1;
               presented_d = presented_q + 1'b1;
               state_d     = S_ISSUE;
               if (last_pair) begin
                  epoch_done_d = 1'b1;
                  epoch_d      = epoch_q + 1'b1;
                  idx_d        = '0;
                  presented_d  = '0;
                  if (final_epoch) begin
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     state_d = S_IDLE;
                  end else begin
                     perm_reload = 1'b1;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abort beats everything, including a same-cycle accept or start.
      if (abort_in) begin
         state_d      = S_IDLE;
         valid_d      = 1'b0;
         busy_d       = 1'b0;
         done_d       = 1'b0;
         epoch_done_d = 1'b0;
         perm_reload  = 1'b0;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q       <= S_IDLE;
         num_samples_q <= '0;
         num_epochs_q  <= '0;
         presented_q   <= '0;
         epoch_q       <= '0;
         idx_q         <= '0;
         med_addr_q    <= '0;
         sample_addr_q <= '0;
         x_q           <= '0;
         y_q           <= '0;
         valid_q       <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         epoch_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         num_samples_q <= num_samples_d;
         num_epochs_q  <= num_epochs_d;
         presented_q   <= presented_d;
         epoch_q       <= epoch_d;
         idx_q         <= idx_d;
         med_addr_q    <= med_addr_d;
         sample_addr_q <= sample_addr_d;
         x_q           <= x_d;
         y_q           <= y_d;
         valid_q       <= valid_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         epoch_done_q  <= epoch_done_d;
      end
   end

   assign med_addr_out    = med_addr_q;
   assign x_out           = x_q;
   assign y_out           = y_q;
   assign sample_addr_out = sample_addr_q;
   assign valid_out       = valid_q;
   assign last_out        = valid_q & last_pair;
   assign epoch_out       = epoch_q;
   assign epoch_done_out  = epoch_done_q;
   assign done_out        = done_q;
   assign busy_out        = busy_q;

endmodule
